// File: rtl/msched_pkg.sv
// Shared types and constants for the match frame scheduler: FSM states,
// bank-select widths, bank reset assignment.
package msched_pkg;

    localparam int unsigned LB_W = 2;
    localparam int unsigned RB_W = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        LAUNCH = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [LB_W-1:0] WL_RST = LB_W'(0);
    localparam logic [LB_W-1:0] RL_RST = LB_W'(1);
    localparam logic [LB_W-1:0] RP_RST = LB_W'(2);
    localparam logic [RB_W-1:0] WR_RST = RB_W'(0);
    localparam logic [RB_W-1:0] RR_RST = RB_W'(1);

    // Current bank roles for both descriptor RAM groups
    typedef struct packed {
        logic [LB_W-1:0] wl;
        logic [LB_W-1:0] rl;
        logic [LB_W-1:0] rp;
        logic [RB_W-1:0] wr;
        logic [RB_W-1:0] rr;
    } bank_set_t;

    localparam bank_set_t BANK_RST = '{wl: WL_RST, rl: RL_RST, rp: RP_RST,
                                       wr: WR_RST, rr: RR_RST};

endpackage

// File: rtl/msched_half_trk.sv
// Per-side frame completion tracker: holds the got flag and latched descriptor
// count, drives write-ready, and flags completions that arrive with no free bank.
module msched_half_trk #(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_done,
    input  logic [DW-1:0] desnum,
    input  logic          clear,
    output logic          got,
    output logic [DW-1:0] count,
    output logic          wr_ready,
    output logic          drop_c
);

    // A completion while the half is still held has nowhere to go
    assign drop_c = frame_done & got;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got      <= 1'b0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else if (clear) begin
            got      <= 1'b0;
            wr_ready <= 1'b1;
        end else if (frame_done && !got) begin
            got      <= 1'b1;
            count    <= desnum;
            wr_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/match_frame_sched.sv
// Frame-level scheduler in front of the matcher: rotates descriptor banks,
// latches counts and launches the matcher. Optional statistics via MSCHED_STATS_EN.
module match_frame_sched
    import msched_pkg::*;
#(
    parameter int unsigned DW    = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_done_l,
    input  logic [DW-1:0]    desnum_l,
    input  logic             frame_done_r,
    input  logic [DW-1:0]    desnum_r,
    output logic             wr_ready_l,
    output logic             wr_ready_r,
    output logic [LB_W-1:0]  wl_bank,
    output logic [RB_W-1:0]  wr_bank,
    output logic [LB_W-1:0]  rl_bank,
    output logic [LB_W-1:0]  rp_bank,
    output logic [RB_W-1:0]  rr_bank,
    output logic [DW-1:0]    desnum_rl,
    output logic [DW-1:0]    desnum_rp,
    output logic [DW-1:0]    desnum_rr,
    output logic             match_start,
    input  logic             match_done,
    output logic             busy,
    output logic             drop_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    state_t          state;
    state_t          state_nxt;
    logic            rotate_c;
    logic            launch_c;
    logic            prev_valid;
    bank_set_t       banks;
    logic            got_l;
    logic            got_r;
    logic [DW-1:0]   cnt_l;
    logic [DW-1:0]   cnt_r;
    logic            drop_l_c;
    logic            drop_r_c;

    msched_half_trk #(.DW(DW)) u_trk_l (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done_l),
        .desnum     (desnum_l),
        .clear      (rotate_c),
        .got        (got_l),
        .count      (cnt_l),
        .wr_ready   (wr_ready_l),
        .drop_c     (drop_l_c)
    );

    msched_half_trk #(.DW(DW)) u_trk_r (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done_r),
        .desnum     (desnum_r),
        .clear      (rotate_c),
        .got        (got_r),
        .count      (cnt_r),
        .wr_ready   (wr_ready_r),
        .drop_c     (drop_r_c)
    );

    // Next-state: launch only once a previous-left frame exists and L is non-empty
    always_comb begin
        state_nxt = state;
        rotate_c  = 1'b0;
        launch_c  = 1'b0;
        case (state)
            IDLE: begin
                if (got_l && got_r) begin
                    state_nxt = ROTATE;
                end
            end
            ROTATE: begin
                rotate_c  = 1'b1;
                launch_c  = prev_valid && (cnt_l != '0);
                state_nxt = launch_c ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (match_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bank rotation, count hand-off and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            banks       <= BANK_RST;
            desnum_rl   <= '0;
            desnum_rp   <= '0;
            desnum_rr   <= '0;
            prev_valid  <= 1'b0;
            match_start <= 1'b0;
            busy        <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            match_start <= (state_nxt == LAUNCH);
            busy        <= (state_nxt == LAUNCH) || (state_nxt == RUN);
            drop_err    <= drop_l_c | drop_r_c;
            if (rotate_c) begin
                banks      <= '{wl: banks.rp, rl: banks.wl, rp: banks.rl,
                                wr: banks.rr, rr: banks.wr};
                desnum_rp  <= desnum_rl;
                desnum_rl  <= cnt_l;
                desnum_rr  <= cnt_r;
                prev_valid <= 1'b1;
            end
        end
    end

    assign wl_bank = banks.wl;
    assign rl_bank = banks.rl;
    assign rp_bank = banks.rp;
    assign wr_bank = banks.wr;
    assign rr_bank = banks.rr;

`ifdef MSCHED_STATS_EN
    logic [CNT_W-1:0] frame_q;
    logic [CNT_W-1:0] drop_q;

    // Launch count wraps; drop count saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            if (state == LAUNCH) begin
                frame_q <= frame_q + CNT_W'(1);
            end
            if (drop_err && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_match_frame_sched.sv
// Scoreboard bench for match_frame_sched: directed test-plan sequence followed
// by randomized frames, checked against a bank/queue reference model.
module tb_match_frame_sched;

    localparam int unsigned DW    = 10;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             frame_done_l;
    logic [DW-1:0]    desnum_l;
    logic             frame_done_r;
    logic [DW-1:0]    desnum_r;
    logic             wr_ready_l;
    logic             wr_ready_r;
    logic [1:0]       wl_bank;
    logic             wr_bank;
    logic [1:0]       rl_bank;
    logic [1:0]       rp_bank;
    logic             rr_bank;
    logic [DW-1:0]    desnum_rl;
    logic [DW-1:0]    desnum_rp;
    logic [DW-1:0]    desnum_rr;
    logic             match_start;
    logic             match_done;
    logic             busy;
    logic             drop_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;

    match_frame_sched #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_done_l (frame_done_l),
        .desnum_l     (desnum_l),
        .frame_done_r (frame_done_r),
        .desnum_r     (desnum_r),
        .wr_ready_l   (wr_ready_l),
        .wr_ready_r   (wr_ready_r),
        .wl_bank      (wl_bank),
        .wr_bank      (wr_bank),
        .rl_bank      (rl_bank),
        .rp_bank      (rp_bank),
        .rr_bank      (rr_bank),
        .desnum_rl    (desnum_rl),
        .desnum_rp    (desnum_rp),
        .desnum_rr    (desnum_rr),
        .match_start  (match_start),
        .match_done   (match_done),
        .busy         (busy),
        .drop_err     (drop_err),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 rotating, 2 starting, 3 matcher running
    typedef struct {
        int rl, rp, rr, drl, drp, drr;
    } launch_t;

    int      m_phase;
    bit      m_got [2];
    int      m_cnt [2];
    bit      m_prev;
    int      m_lb  [3];   // write, current-left, previous-left
    int      m_rb  [2];   // write, current-right
    int      m_drl, m_drp, m_drr;
    bit      m_drop;
    int      m_frames, m_drops;
    int      cyc;
    launch_t lq[$];
    int      dq[$];

    function automatic void m_reset();
        m_phase = 0;
        m_got[0] = 0; m_got[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_prev = 0;
        m_lb[0] = 0; m_lb[1] = 1; m_lb[2] = 2;
        m_rb[0] = 0; m_rb[1] = 1;
        m_drl = 0; m_drp = 0; m_drr = 0;
        m_drop = 0;
        m_frames = 0; m_drops = 0;
        lq.delete();
        dq.delete();
    endfunction

    function automatic void m_step();
        bit fd[2];
        int dn[2];
        bit clr = 0;
        int tmp;
        launch_t rec;
        fd[0] = frame_done_l; dn[0] = int'(desnum_l);
        fd[1] = frame_done_r; dn[1] = int'(desnum_r);
        cyc++;
        if (m_drop && m_drops < 65535) m_drops++;
        m_drop = (fd[0] && m_got[0]) || (fd[1] && m_got[1]);
        if (m_drop) dq.push_back(cyc);
        case (m_phase)
            0: if (m_got[0] && m_got[1]) m_phase = 1;
            1: begin
                tmp = m_lb[2];
                m_lb[2] = m_lb[1];
                m_lb[1] = m_lb[0];
                m_lb[0] = tmp;
                tmp = m_rb[0]; m_rb[0] = m_rb[1]; m_rb[1] = tmp;
                m_drp = m_drl;
                m_drl = m_cnt[0];
                m_drr = m_cnt[1];
                clr = 1;
                if (m_prev && m_cnt[0] != 0) begin
                    m_phase = 2;
                    rec.rl = m_lb[1]; rec.rp = m_lb[2]; rec.rr = m_rb[1];
                    rec.drl = m_drl; rec.drp = m_drp; rec.drr = m_drr;
                    lq.push_back(rec);
                end else begin
                    m_phase = 0;
                end
                m_prev = 1;
            end
            2: begin
                m_phase = 3;
                m_frames++;
            end
            default: if (match_done) m_phase = 0;
        endcase
        for (int s = 0; s < 2; s++) begin
            if (clr) m_got[s] = 0;
            else if (fd[s] && !m_got[s]) begin
                m_got[s] = 1;
                m_cnt[s] = dn[s];
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else m_step();
    end

    // Monitor: per-cycle output compare plus queue pops on start and drop pulses
    always @(negedge clk) begin
        launch_t rec;
        if (rst) begin
            chk("wl_bank", wl_bank, m_lb[0]);
            chk("rl_bank", rl_bank, m_lb[1]);
            chk("rp_bank", rp_bank, m_lb[2]);
            chk("wr_bank", wr_bank, m_rb[0]);
            chk("rr_bank", rr_bank, m_rb[1]);
            chk("desnum_rl", desnum_rl, m_drl);
            chk("desnum_rp", desnum_rp, m_drp);
            chk("desnum_rr", desnum_rr, m_drr);
            chk("busy", busy, (m_phase >= 2) ? 1 : 0);
            chk("match_start", match_start, (m_phase == 2) ? 1 : 0);
            chk("wr_ready_l", wr_ready_l, m_got[0] ? 0 : 1);
            chk("wr_ready_r", wr_ready_r, m_got[1] ? 0 : 1);
`ifdef MSCHED_STATS_EN
            chk("frame_cnt", frame_cnt, m_frames % 65536);
            chk("drop_cnt", drop_cnt, m_drops);
`else
            chk("frame_cnt", frame_cnt, 0);
            chk("drop_cnt", drop_cnt, 0);
`endif
            if (match_start) begin
                if (lq.size() == 0) chk("launch_unexpected", 1, 0);
                else begin
                    rec = lq.pop_front();
                    chk("launch_rl", rl_bank, rec.rl);
                    chk("launch_rp", rp_bank, rec.rp);
                    chk("launch_rr", rr_bank, rec.rr);
                    chk("launch_drl", desnum_rl, rec.drl);
                    chk("launch_drp", desnum_rp, rec.drp);
                    chk("launch_drr", desnum_rr, rec.drr);
                end
            end
            if (drop_err) begin
                if (dq.size() == 0) chk("drop_unexpected", 1, 0);
                else chk("drop_cycle", cyc, dq.pop_front());
            end
        end
    end

    task automatic drive(input bit fl, input int dl, input bit fr, input int dr, input bit md);
        frame_done_l = fl; desnum_l = DW'(dl);
        frame_done_r = fr; desnum_r = DW'(dr);
        match_done   = md;
        @(posedge clk);
        #2;
        frame_done_l = 1'b0;
        frame_done_r = 1'b0;
        match_done   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wl"}, wl_bank, 0);
        chk({tag, "_rl"}, rl_bank, 1);
        chk({tag, "_rp"}, rp_bank, 2);
        chk({tag, "_wr"}, wr_bank, 0);
        chk({tag, "_rr"}, rr_bank, 1);
        chk({tag, "_drl"}, desnum_rl, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, match_start, 0);
        chk({tag, "_rdy_l"}, wr_ready_l, 1);
        chk({tag, "_rdy_r"}, wr_ready_r, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fl, fr, md;
        int dl, dr;
        m_reset();
        cyc = 0;
        rst = 1'b0;
        frame_done_l = 1'b0; desnum_l = '0;
        frame_done_r = 1'b0; desnum_r = '0;
        match_done   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("por");
        rst = 1'b1;
        idle(2);

        // First frame: rotates without launching
        drive(1, 5, 1, 7, 0);
        idle(4);
        chk("f1_rl", rl_bank, 0);
        chk("f1_rp", rp_bank, 1);
        chk("f1_wl", wl_bank, 2);
        chk("f1_wr", wr_bank, 1);
        chk("f1_rr", rr_bank, 0);
        chk("f1_busy", busy, 0);

        // Second frame with staggered halves launches
        drive(1, 8, 0, 0, 0);
        idle(3);
        drive(0, 0, 1, 6, 0);
        idle(4);
        chk("f2_drl", desnum_rl, 8);
        chk("f2_drp", desnum_rp, 5);
        chk("f2_drr", desnum_rr, 6);
        chk("f2_rl", rl_bank, 2);
        chk("f2_busy", busy, 1);

        // Full next frame during RUN, then an extra left completion is dropped
        drive(1, 3, 1, 3, 0);
        idle(3);
        drive(1, 11, 0, 0, 0);
        idle(15);
        drive(0, 0, 0, 0, 1);
        idle(5);
        chk("f3_drp", desnum_rp, 8);
        chk("f3_drl", desnum_rl, 3);
        chk("f3_busy", busy, 1);
        drive(0, 0, 0, 0, 1);
        idle(2);

        // Empty left frame rotates without launching
        drive(1, 0, 1, 4, 0);
        idle(6);
        chk("f4_busy", busy, 0);
        chk("f4_drl", desnum_rl, 0);

        // Reset asserted mid-RUN
        drive(1, 9, 1, 2, 0);
        idle(5);
        chk("f5_busy", busy, 1);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrun");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        idle(2);
        chk_reset_outputs("post");

        // Randomized frames and matcher completions
        for (int i = 0; i < 3000; i++) begin
            fl = ($urandom_range(0, 9) == 0);
            fr = ($urandom_range(0, 9) == 0);
            dl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
            dr = int'($urandom_range(0, 1023));
            md = (m_phase == 3 && $urandom_range(0, 15) == 0) || ($urandom_range(0, 63) == 0);
            drive(fl, dl, fr, dr, md);
        end
        idle(4);
        drive(0, 0, 0, 0, 1);
        idle(6);
        drive(0, 0, 0, 0, 1);
        idle(4);
        chk("launch_q_empty", lq.size(), 0);
        chk("drop_q_empty", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/match_frame_sched.md
Name: match_frame_sched

Overview:
- Frame-level scheduler that sits in front of Match_Ctrl.
- Owns the bank assignment of the descriptor RAMs: three left-frame banks (write / current-left / previous-left) and two right-frame banks (write / current-right).
- Collects per-frame completion from the left and right feature extractors, rotates banks, and latches descriptor counts.
- Pulses the matcher start and holds banks stable until the matcher reports done; back-pressures extractors when no free write bank exists.

Parameters:
- DW, 10, descriptor-count width; equals RAM address width.
- CNT_W, 16, statistics counter width (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_done_l  in  1  1-cycle pulse: left extractor finished writing bank wl_bank
- desnum_l  in  DW  left descriptor count, valid with frame_done_l
- frame_done_r  in  1  1-cycle pulse: right extractor finished writing bank wr_bank
- desnum_r  in  DW  right descriptor count, valid with frame_done_r
- wr_ready_l  out  1  left extractor may write wl_bank
- wr_ready_r  out  1  right extractor may write wr_bank
- wl_bank  out  2  left write bank select (0..2)
- wr_bank  out  1  right write bank select
- rl_bank  out  2  bank driving matcher R_L port
- rp_bank  out  2  bank driving matcher R_P port
- rr_bank  out  1  bank driving matcher R_R port
- desnum_rl / desnum_rp / desnum_rr  out  DW each  counts to matcher DesNum_RL/RP/RR
- match_start  out  1  1-cycle start pulse to matcher
- match_done  in  1  1-cycle pulse: matcher returned to idle
- busy  out  1  high in LAUNCH and RUN
- drop_err  out  1  1-cycle pulse: frame_done received while the corresponding wr_ready was low
- frame_cnt  out  CNT_W  launched-frame count (optional feature)
- drop_cnt  out  CNT_W  dropped-half count (optional feature)

Behaviour:
- Reset values (async, rst=0):
  - state = IDLE.
  - wl_bank=0, rl_bank=1, rp_bank=2, wr_bank=0, rr_bank=1.
  - All desnum_* = 0.
  - match_start=0, busy=0, drop_err=0.
  - got_l=got_r=0, prev_valid=0, counters 0.
  - wr_ready_l = wr_ready_r = 1.
- Half tracking, per side:
  - got_x sets on frame_done_x when wr_ready_x=1, and latches desnum_x.
  - wr_ready_x = ~got_x.
  - frame_done_x with wr_ready_x=0: ignored (latched count unchanged) and drop_err pulses the next cycle.
  - Both sides may complete in the same cycle.
- States:
  - IDLE: if got_l & got_r -> ROTATE.
  - ROTATE (1 cycle):
    - Left rotation: rp_bank<=rl_bank, rl_bank<=wl_bank, wl_bank<=old rp_bank.
    - Right swap: wr_bank<=rr_bank, rr_bank<=wr_bank.
    - Counts: desnum_rp<=desnum_rl, desnum_rl<=latched L, desnum_rr<=latched R.
    - Clear got_l/got_r.
    - If prev_valid=1 and latched L != 0 -> LAUNCH; else -> IDLE. prev_valid<=1 in either case.
    - An L count of 0 or the first frame after reset rotates without launching.
  - LAUNCH: match_start=1 for exactly one cycle -> RUN.
  - RUN: hold all bank/count outputs; on match_done -> IDLE.
  - Unreachable encodings -> IDLE.
- Latency: for the completing frame_done in cycle 0, ROTATE occurs in cycle 2 and match_start is high in cycle 3. Bank/count outputs are valid from cycle 3.
- Overlap:
  - The extractors may write the next frame during RUN.
  - If both halves complete in RUN, the frame waits. On match_done the state goes to IDLE, then ROTATE the next cycle (no frame lost).
  - A third frame before match_done is dropped (wr_ready low).
- match_done outside RUN: ignored.
- Reset mid-RUN: all state returns to reset values; the matcher is reset by the same rst tree.

Optional Feature:
- MSCHED_STATS_EN defined:
  - frame_cnt increments (wrapping) on each LAUNCH.
  - drop_cnt increments (saturating at all-ones) on each drop_err.
- Undefined: both ports tied to 0 and the counters are not built.

Decomposition:
- Package msched_pkg holds:
  - State enum (IDLE, ROTATE, LAUNCH, RUN).
  - Bank reset constants (WL_RST=0, RL_RST=1, RP_RST=2, WR_RST=0, RR_RST=1).
  - Bank-select width constants.
- Sub-module msched_half_trk is instantiated twice (left, right). It contains the got flag, count latch, wr_ready and drop detection, and takes a clear input from ROTATE.

Test Plan:
- First frame after reset, desnum_l=5, desnum_r=7 same cycle -> no match_start; rl_bank=0, rp_bank=1, wl_bank=2, wr_bank=1, rr_bank=0; desnum_rl=5, desnum_rr=7.
- Second frame, L=8 at cycle 0, R=6 at cycle 4 -> match_start in cycle 7 only; desnum_rl=8, desnum_rp=5, desnum_rr=6; rl_bank=2, rp_bank=0, wl_bank=1.
- During RUN, complete a full next frame (L=3, R=3); assert match_done 20 cycles later -> IDLE then ROTATE then match_start 3 cycles after match_done; desnum_rp=8.
- While that frame is pending, pulse frame_done_l again -> drop_err one cycle; latched L stays 3; with MSCHED_STATS_EN, drop_cnt=1.
- Frame with desnum_l=0 after a valid frame -> rotation occurs, no match_start, busy stays 0.
- Assert rst low during RUN for 2 cycles -> all outputs at reset values immediately; match_done pulses after reset are ignored.
